// File: rtl/mcbsp_xfer_scheduler.sv
// mcbsp_xfer_scheduler: round-robin arbiter that shares one McBSP master link
// between NUM_REQ requesters. Each grant performs one 32-bit transfer,
// followed by a forced idle gap so the master can return to idle.
module mcbsp_xfer_scheduler #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned TIMEOUT    = 4096,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [2*NUM_REQ-1:0]    req_mode,
    input  logic [32*NUM_REQ-1:0]   req_tx_data,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      done,
    output logic                    timeout_err,
    output logic [31:0]             rx_data,
    output logic                    busy,
    output logic                    mc_transform_en,
    output logic                    mc_tx_data_en,
    output logic [31:0]             mc_tx_data,
    input  logic                    mc_rx_ready,
    input  logic                    mc_tx_ready,
    input  logic [31:0]             mc_rx_data
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [NUM_REQ-1:0] GNT_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [31:0]        tx_data_q;
    logic [1:0]         mode_q;
    logic               tx_pend_q, rx_pend_q, abort_q;
    logic [31:0]        cap_q, rx_data_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;

    logic [31:0]        tx_word   [NUM_REQ];
    logic [1:0]         mode_word [NUM_REQ];
    logic               arb_found;
    logic [PTR_W-1:0]   arb_idx;
    logic [PTR_W-1:0]   cand_idx;
    int unsigned        cand;
    logic               pend_any, timeout_hit;

    // Unpack the flat per-requester buses into indexable words.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            tx_word[i]   = req_tx_data[32*i +: 32];
            mode_word[i] = req_mode[2*i +: 2];
        end
    end

    // Round-robin search: first asserted request at or after the pointer.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = 32'(ptr_q) + off;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = PTR_W'(cand);
            if (!arb_found && req[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    assign pend_any    = tx_pend_q | rx_pend_q;
    assign timeout_hit = (state_q == S_WAIT) && pend_any &&
                         (wait_cnt_q == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (arb_found)
                        state_d = (mode_word[arb_idx] == 2'b00) ? S_DONE : S_WAIT;
            S_WAIT: if (timeout_hit || !pend_any) state_d = S_DONE;
            S_DONE: state_d = S_GAP;
            S_GAP:  if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE) ? gnt_q : '0;
        timeout_err = (state_q == S_DONE) && abort_q;
    end

    // Transfer datapath: grant latch, pending flags, capture and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            gnt_q      <= '0;
            tx_data_q  <= '0;
            mode_q     <= '0;
            tx_pend_q  <= 1'b0;
            rx_pend_q  <= 1'b0;
            abort_q    <= 1'b0;
            cap_q      <= '0;
            rx_data_q  <= '0;
            wait_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (arb_found) begin
                    gnt_q      <= GNT_ONE << arb_idx;
                    ptr_q      <= (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    tx_data_q  <= tx_word[arb_idx];
                    mode_q     <= mode_word[arb_idx];
                    tx_pend_q  <= mode_word[arb_idx][0];
                    rx_pend_q  <= mode_word[arb_idx][1];
                    abort_q    <= 1'b0;
                    wait_cnt_q <= '0;
                end
                S_WAIT: begin
                    wait_cnt_q <= wait_cnt_q + 1'b1;
                    if (timeout_hit) begin
                        tx_pend_q <= 1'b0;
                        rx_pend_q <= 1'b0;
                        abort_q   <= 1'b1;
                    end else begin
                        if (mc_tx_ready) tx_pend_q <= 1'b0;
                        if (mc_rx_ready && rx_pend_q) begin
                            rx_pend_q <= 1'b0;
                            cap_q     <= mc_rx_data;
                        end
                        // Normal completion: publish the capture as DONE is entered.
                        if (!pend_any && mode_q[1]) rx_data_q <= cap_q;
                    end
                end
                S_DONE: begin
                    gnt_q     <= '0;
                    gap_cnt_q <= '0;
                end
                S_GAP: gap_cnt_q <= gap_cnt_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign gnt             = gnt_q;
    assign rx_data         = rx_data_q;
    assign mc_tx_data      = tx_data_q;
    assign mc_tx_data_en   = tx_pend_q;
    assign mc_transform_en = rx_pend_q;
endmodule

// File: tb/tb_mcbsp_xfer_scheduler.sv
// Bench for mcbsp_xfer_scheduler: directed scenarios with literal expectations
// plus a randomized phase, all cross-checked every cycle against a
// transaction-level model (grant cycle, completion cycle, gap window).
module tb_mcbsp_xfer_scheduler;
    localparam int NR  = 4;
    localparam int TO  = 64;
    localparam int GAP = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [2*NR-1:0]   req_mode;
    logic [32*NR-1:0]  req_tx_data;
    logic [NR-1:0]     gnt, done;
    logic              timeout_err, busy, mc_transform_en, mc_tx_data_en;
    logic [31:0]       rx_data, mc_tx_data, mc_rx_data;
    logic              mc_rx_ready, mc_tx_ready;

    mcbsp_xfer_scheduler #(.NUM_REQ(NR), .TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .req(req), .req_mode(req_mode), .req_tx_data(req_tx_data),
        .gnt(gnt), .done(done), .timeout_err(timeout_err), .rx_data(rx_data), .busy(busy),
        .mc_transform_en(mc_transform_en), .mc_tx_data_en(mc_tx_data_en),
        .mc_tx_data(mc_tx_data), .mc_rx_ready(mc_rx_ready), .mc_tx_ready(mc_tx_ready),
        .mc_rx_data(mc_rx_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit          mvalid = 0;
    bit          m_act = 0;
    int          m_own = 0, m_ptr = 0, m_gcyc = 0, m_fin = -1, m_lastfin = -100;
    logic [1:0]  m_mode = '0;
    logic [31:0] m_word = '0, m_cap = '0, m_rx = '0;
    bit          m_txl = 0, m_rxl = 0, m_abort = 0;
    int          c, n, win, idx;
    logic [NR-1:0] one = 1;
    logic [NR-1:0] e_gnt, e_done;

    initial begin
        forever begin
            @(posedge clk);
            c = cyc;          // cycle that just ended
            cyc++;
            n = cyc;          // cycle now starting
            if (rst) begin
                mvalid = 1; m_act = 0; m_txl = 0; m_rxl = 0; m_abort = 0;
                m_word = '0; m_rx = '0; m_ptr = 0; m_fin = -1;
                m_lastfin = n - GAP - 1;
            end else if (mvalid) begin
                if (m_act && c == m_fin) m_act = 0;
                if (m_act && m_fin < 0) begin
                    if ((m_txl || m_rxl) && (c - m_gcyc == TO - 1)) begin
                        m_abort = 1; m_txl = 0; m_rxl = 0; m_fin = n;
                    end else if (m_txl || m_rxl) begin
                        if (mc_tx_ready) m_txl = 0;
                        if (mc_rx_ready && m_rxl) begin m_rxl = 0; m_cap = mc_rx_data; end
                        if (!m_txl && !m_rxl) m_fin = c + 2;
                    end
                end else if (!m_act && c > m_lastfin + GAP && req != 0) begin
                    win = -1;
                    for (int off = 0; off < NR; off++) begin
                        idx = (m_ptr + off) % NR;
                        if (win < 0 && req[idx]) win = idx;
                    end
                    m_act  = 1; m_own = win; m_ptr = (win + 1) % NR;
                    m_mode = req_mode[2*win +: 2];
                    m_word = req_tx_data[32*win +: 32];
                    m_txl  = m_mode[0]; m_rxl = m_mode[1];
                    m_gcyc = n; m_abort = 0;
                    m_fin  = (m_mode == 2'b00) ? n : -1;
                end
                if (m_act && n == m_fin) begin
                    m_lastfin = n;
                    if (m_mode[1] && !m_abort) m_rx = m_cap;
                end
            end
            #1;
            if (mvalid) begin
                e_gnt  = m_act ? (one << m_own) : '0;
                e_done = (m_act && n == m_fin) ? e_gnt : '0;
                check("gnt",         32'(gnt),             32'(e_gnt));
                check("done",        32'(done),            32'(e_done));
                check("timeout_err", 32'(timeout_err),     32'((e_done != 0) && m_abort));
                check("busy",        32'(busy),            32'(m_act || (n <= m_lastfin + GAP)));
                check("tx_en",       32'(mc_tx_data_en),   32'(m_txl));
                check("rx_en",       32'(mc_transform_en), 32'(m_rxl));
                check("mc_tx_data",  mc_tx_data,           m_word);
                check("rx_data",     rx_data,              m_rx);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic goto(input int base, input int k);
        while (cyc < base + k) @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [1:0] m, input logic [31:0] w);
        req[i] = 1'b1;
        req_mode[2*i +: 2] = m;
        req_tx_data[32*i +: 32] = w;
    endtask

    task automatic pulse(input int base, input int k, input logic tx, input logic rx,
                         input logic [31:0] d);
        goto(base, k);
        mc_tx_ready = tx; mc_rx_ready = rx; mc_rx_data = d;
        @(negedge clk);
        mc_tx_ready = 1'b0; mc_rx_ready = 1'b0;
    endtask

    task automatic wait_gnt(input int limit, output int at);
        int k = 0;
        while (gnt == 0 && k < limit) begin @(negedge clk); k++; end
        at = cyc;
        if (gnt == 0) begin
            checks++; errors++;
            $display("FAIL wait_gnt: got no grant within %0d cycles, required one", limit);
        end
    endtask

    task automatic wait_done(input int limit, output int at);
        int k = 0;
        while (done == 0 && k < limit) begin @(negedge clk); k++; end
        at = cyc;
        if (done == 0) begin
            checks++; errors++;
            $display("FAIL wait_done: got no done within %0d cycles, required one", limit);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; mc_tx_ready = 1'b0; mc_rx_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic settle();
        repeat (GAP + 4) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    int base, g, d, prev_d, cnt;
    bit in_x, never;
    int rk, td, rd;

    initial begin
        rst = 1'b1; req = '0; req_mode = '0; req_tx_data = '0;
        mc_tx_ready = 1'b0; mc_rx_ready = 1'b0; mc_rx_data = '0;
        do_reset();

        // Single full-duplex transfer
        set_req(0, 2'b11, 32'hA5A5_5A5A); base = cyc;
        goto(base, 1);
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_txd", mc_tx_data, 32'hA5A5_5A5A);
        check("t1_txen", 32'(mc_tx_data_en), 32'h1);
        check("t1_rxen", 32'(mc_transform_en), 32'h1);
        pulse(base, 40, 1'b1, 1'b0, 32'h0);
        check("t1_txen_drop", 32'(mc_tx_data_en), 32'h0);
        check("t1_rxen_hold", 32'(mc_transform_en), 32'h1);
        pulse(base, 45, 1'b0, 1'b1, 32'h1234_5678);
        check("t1_no_early_done", 32'(done), 32'h0);
        goto(base, 47);
        check("t1_done", 32'(done), 32'h1);
        check("t1_rx", rx_data, 32'h1234_5678);
        check("t1_terr", 32'(timeout_err), 32'h0);
        req[0] = 1'b0;
        goto(base, 48);
        check("t1_gnt_clr", 32'(gnt), 32'h0);
        check("t1_busy_gap", 32'(busy), 32'h1);
        settle();

        // Timeout on a receive-only transfer
        set_req(2, 2'b10, 32'h1111_2222); base = cyc;
        goto(base, 1);
        check("t3_gnt", 32'(gnt), 32'h4);
        check("t3_txen", 32'(mc_tx_data_en), 32'h0);
        goto(base, TO);
        check("t3_rxen_wait", 32'(mc_transform_en), 32'h1);
        check("t3_no_done", 32'(done), 32'h0);
        goto(base, TO + 1);
        check("t3_rxen_drop", 32'(mc_transform_en), 32'h0);
        check("t3_done", 32'(done), 32'h4);
        check("t3_terr", 32'(timeout_err), 32'h1);
        check("t3_rx_kept", rx_data, 32'h1234_5678);
        req[2] = 1'b0;
        settle();

        // Round-robin with all four requesting
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 2'b01, 32'h1000_0000 + 32'(i));
        prev_d = -1;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(200, g);
            check("rr_order", 32'(gnt), 32'(one << (k % NR)));
            if (k > 0) check("rr_gap", 32'(g - prev_d), 32'(GAP + 2));
            pulse(g, 10, 1'b1, 1'b0, 32'h0);
            wait_done(50, d);
            check("rr_done_lat", 32'(d - g), 32'd12);
            prev_d = d;
            if (k == 4) req = '0;
            @(negedge clk);
        end
        settle();

        // Simultaneous ready, then stray rx in a transmit-only transfer
        do_reset();
        set_req(1, 2'b11, 32'h0BAD_CAFE); base = cyc;
        pulse(base, 5, 1'b1, 1'b1, 32'hCAFE_F00D);
        check("t4_txen", 32'(mc_tx_data_en), 32'h0);
        check("t4_rxen", 32'(mc_transform_en), 32'h0);
        goto(base, 7);
        check("t4_done", 32'(done), 32'h2);
        check("t4_rx", rx_data, 32'hCAFE_F00D);
        req[1] = 1'b0;
        cnt = 0;
        repeat (20) begin @(negedge clk); if (done != 0) cnt++; end
        check("t4_one_done", 32'(cnt), 32'h0);
        set_req(1, 2'b01, 32'h55AA_55AA); base = cyc;
        pulse(base, 3, 1'b0, 1'b1, 32'hDEAD_BEEF);
        check("t4_stray_rx", rx_data, 32'hCAFE_F00D);
        check("t4_stray_txen", 32'(mc_tx_data_en), 32'h1);
        pulse(base, 6, 1'b1, 1'b0, 32'h0);
        goto(base, 8);
        check("t4b_done", 32'(done), 32'h2);
        check("t4b_rx", rx_data, 32'hCAFE_F00D);
        req[1] = 1'b0;
        settle();

        // Request dropped after grant; no-op mode
        set_req(1, 2'b01, 32'h0000_0077); base = cyc;
        goto(base, 4); req[1] = 1'b0;
        pulse(base, 8, 1'b1, 1'b0, 32'h0);
        goto(base, 10);
        check("t5_done_dropped", 32'(done), 32'h2);
        settle();
        set_req(0, 2'b00, 32'h0000_0099); base = cyc;
        goto(base, 1);
        check("t5_noop_gnt", 32'(gnt), 32'h1);
        check("t5_noop_done", 32'(done), 32'h1);
        check("t5_noop_txen", 32'(mc_tx_data_en), 32'h0);
        check("t5_noop_rxen", 32'(mc_transform_en), 32'h0);
        req[0] = 1'b0;
        goto(base, 2);
        check("t5_noop_done_clr", 32'(done), 32'h0);
        settle();

        // Reset in the middle of WAIT
        set_req(0, 2'b11, 32'hFEED_0001); base = cyc;
        goto(base, 5);
        rst = 1'b1; req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("t6_gnt", 32'(gnt), 32'h0);
        check("t6_done", 32'(done), 32'h0);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_txen", 32'(mc_tx_data_en), 32'h0);
        check("t6_rxen", 32'(mc_transform_en), 32'h0);
        check("t6_rx", rx_data, 32'h0);
        check("t6_txd", mc_tx_data, 32'h0);
        set_req(3, 2'b01, 32'h3333_3333); base = cyc;
        goto(base, 1);
        check("t6_gnt3", 32'(gnt), 32'h8);
        pulse(base, 3, 1'b1, 1'b0, 32'h0);
        wait_done(10, d);
        req[3] = 1'b0;
        settle();

        // Randomized traffic with a responding master
        do_reset();
        in_x = 0; rk = 0; td = 0; rd = 0; never = 0;
        repeat (3000) begin
            @(negedge clk);
            rst = ($urandom_range(0, 799) == 0);
            for (int i = 0; i < NR; i++) begin
                if (done[i]) req[i] = 1'b0;
                else if (gnt[i] && $urandom_range(0, 39) == 0) req[i] = 1'b0;
                else if (!req[i] && !gnt[i] && $urandom_range(0, 5) == 0) req[i] = 1'b1;
            end
            req_mode    = 8'($urandom);
            req_tx_data = {$urandom, $urandom, $urandom, $urandom};
            mc_tx_ready = 1'b0; mc_rx_ready = 1'b0; mc_rx_data = $urandom;
            if (gnt != 0 && !in_x) begin
                in_x = 1; rk = 1;
                td = $urandom_range(1, 20); rd = $urandom_range(1, 20);
                never = ($urandom_range(0, 7) == 0);
            end else if (gnt != 0) rk++;
            else in_x = 0;
            if (in_x) begin
                if (rk == td) mc_tx_ready = 1'b1;
                if (!never && rk == rd) mc_rx_ready = 1'b1;
                if (!never && $urandom_range(0, 29) == 0) mc_rx_ready = 1'b1;
            end else if ($urandom_range(0, 19) == 0) begin
                mc_rx_ready = 1'b1;
            end
        end
        rst = 1'b0; req = '0; mc_tx_ready = 1'b0; mc_rx_ready = 1'b0;
        repeat (TO + GAP + 10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
